cache_port_arbiter: RTL

- Two-requester round-robin arbiter that shares the single CPU-side port of the direct-mapped cache controller between requester A (instruction fetch) and requester B (data load/store).
- Each accepted request is latched, issued to the cache with a valid/ready handshake, and the response is captured one cycle after cache acceptance.
- The response is returned to the originating requester.
- Includes an issue timeout with an error response, plus per-requester saturating grant counters for debug.

---
 rtl/cache_port_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing the cache CPU port between requester A (ifetch)
// and requester B (load/store). One transaction in flight: grant, issue, respond.
module cache_port_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    // requester A
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_rw,
    input  logic [DATA_W-1:0] a_din,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_data,
    output logic              a_rsp_err,
    // requester B
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_rw,
    input  logic [DATA_W-1:0] b_din,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_data,
    output logic              b_rsp_err,
    // cache CPU port
    output logic              c_valid,
    input  logic              c_ready,
    output logic [ADDR_W-1:0] c_addr,
    output logic              c_rw,
    output logic [DATA_W-1:0] c_din,
    input  logic [DATA_W-1:0] c_dout,
    // debug grant counters
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    // Last ISSUE cycle allowed before aborting (timeout counter starts at 0).
    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic                ptr_q, ptr_d;      // 0: favour A, 1: favour B
    logic                owner_q, owner_d;  // 0: A, 1: B
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rw_q, rw_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [7:0]          tmo_q, tmo_d;
    logic [CNT_W-1:0]    cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic                a_rsp_valid_q, a_rsp_valid_d, b_rsp_valid_q, b_rsp_valid_d;
    logic                a_rsp_err_q, a_rsp_err_d, b_rsp_err_q, b_rsp_err_d;
    logic [DATA_W-1:0]   a_rsp_data_q, a_rsp_data_d, b_rsp_data_q, b_rsp_data_d;
    logic                grant_a, grant_b;

    // Grant selection; ready is gated by reset so it reads 0 while rst_n is low.
    always_comb begin
        grant_a = a_valid && (!b_valid || !ptr_q);
        grant_b = b_valid && (!a_valid || ptr_q);
        a_ready = rst_n && (state_q == StIdle) && grant_a;
        b_ready = rst_n && (state_q == StIdle) && grant_b;
    end

    // Next-state, holding registers, counters and response pulses.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        rw_d          = rw_q;
        din_d         = din_q;
        tmo_d         = tmo_q;
        cnt_a_d       = cnt_a_q;
        cnt_b_d       = cnt_b_q;
        a_rsp_valid_d = 1'b0;
        a_rsp_data_d  = '0;
        a_rsp_err_d   = 1'b0;
        b_rsp_valid_d = 1'b0;
        b_rsp_data_d  = '0;
        b_rsp_err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_a) begin
                    owner_d = 1'b0;
                    addr_d  = a_addr;
                    rw_d    = a_rw;
                    din_d   = a_din;
                    cnt_a_d = (cnt_a_q == '1) ? cnt_a_q : cnt_a_q + 1'b1;
                    tmo_d   = '0;
                    state_d = StIssue;
                end else if (grant_b) begin
                    owner_d = 1'b1;
                    addr_d  = b_addr;
                    rw_d    = b_rw;
                    din_d   = b_din;
                    cnt_b_d = (cnt_b_q == '1) ? cnt_b_q : cnt_b_q + 1'b1;
                    tmo_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (c_ready) begin
                    state_d = StResp;
                end else if (tmo_q == TmoLast) begin
                    // Abort: error response to the owner, pointer flips.
                    a_rsp_valid_d = !owner_q;
                    a_rsp_err_d   = !owner_q;
                    b_rsp_valid_d = owner_q;
                    b_rsp_err_d   = owner_q;
                    ptr_d         = !ptr_q;
                    state_d       = StIdle;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StResp: begin
                // c_dout is valid in this cycle (one after acceptance).
                a_rsp_valid_d = !owner_q;
                b_rsp_valid_d = owner_q;
                if (!owner_q && !rw_q) a_rsp_data_d = c_dout;
                if (owner_q && !rw_q)  b_rsp_data_d = c_dout;
                ptr_d   = !owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers, asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ptr_q         <= 1'b0;
            owner_q       <= 1'b0;
            addr_q        <= '0;
            rw_q          <= 1'b0;
            din_q         <= '0;
            tmo_q         <= '0;
            cnt_a_q       <= '0;
            cnt_b_q       <= '0;
            a_rsp_valid_q <= 1'b0;
            a_rsp_data_q  <= '0;
            a_rsp_err_q   <= 1'b0;
            b_rsp_valid_q <= 1'b0;
            b_rsp_data_q  <= '0;
            b_rsp_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            addr_q        <= addr_d;
            rw_q          <= rw_d;
            din_q         <= din_d;
            tmo_q         <= tmo_d;
            cnt_a_q       <= cnt_a_d;
            cnt_b_q       <= cnt_b_d;
            a_rsp_valid_q <= a_rsp_valid_d;
            a_rsp_data_q  <= a_rsp_data_d;
            a_rsp_err_q   <= a_rsp_err_d;
            b_rsp_valid_q <= b_rsp_valid_d;
            b_rsp_data_q  <= b_rsp_data_d;
            b_rsp_err_q   <= b_rsp_err_d;
        end
    end

    // Cache port driven straight from the holding registers while issuing.
    always_comb begin
        c_valid     = (state_q == StIssue);
        c_addr      = addr_q;
        c_rw        = rw_q;
        c_din       = din_q;
        cnt_a       = cnt_a_q;
        cnt_b       = cnt_b_q;
        a_rsp_valid = a_rsp_valid_q;
        a_rsp_data  = a_rsp_data_q;
        a_rsp_err   = a_rsp_err_q;
        b_rsp_valid = b_rsp_valid_q;
        b_rsp_data  = b_rsp_data_q;
        b_rsp_err   = b_rsp_err_q;
    end

endmodule
